// File: rtl/flex_cnt_pkg.sv
// ---------------------------------------------------------------------------
// flex_cnt_pkg
// Shared types and helpers for the flex_counter_ud family.
//   cnt_mode_t : terminal behaviour selector (wrap-to-1, wrap-to-0, saturate)
//   base_of()  : lower terminal value (0 or 1) for a given mode/rollover_val
// ---------------------------------------------------------------------------
package flex_cnt_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP1 = 2'b00,
      MODE_WRAP0 = 2'b01,
      MODE_SAT   = 2'b10,
      MODE_RSVD  = 2'b11
   } cnt_mode_t;

   // Lower terminal is 1 only for the legacy wrap-to-1 behaviour (the reserved
   // encoding aliases it). With rollover_val==0 a base of 1 would sit above
   // the upper terminal, so the base drops to 0 there.
   function automatic logic base_of(input cnt_mode_t mode,
                                    input logic [31:0] rollover_val);
      return ((mode == MODE_WRAP1) || (mode == MODE_RSVD)) &&
             (rollover_val != 32'd0);
   endfunction

endpackage

// File: rtl/flex_cnt_step.sv
// ---------------------------------------------------------------------------
// flex_cnt_step
// Purely combinational one-step calculation for an up/down flex counter.
// Ports:
//   i_count          current count
//   i_count_up       1 = increment, 0 = decrement
//   i_mode           cnt_mode_t encoding of terminal behaviour
//   i_rollover_val   upper terminal value
//   o_next_count     count after one enabled step
//   o_terminal_event 1 when this step hits/crosses the terminal
//   o_terminal_val   terminal for the current direction (flag compare value)
// ---------------------------------------------------------------------------
module flex_cnt_step
   import flex_cnt_pkg::*;
#(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic [NUM_CNT_BITS-1:0] i_count,
   input  logic                    i_count_up,
   input  logic [1:0]              i_mode,
   input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
   output logic [NUM_CNT_BITS-1:0] o_next_count,
   output logic                    o_terminal_event,
   output logic [NUM_CNT_BITS-1:0] o_terminal_val
);

   localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

   cnt_mode_t                 w_mode;
   logic                      w_sat;
   logic [NUM_CNT_BITS-1:0]   w_base;

   assign w_mode = cnt_mode_t'(i_mode);
   assign w_sat  = (w_mode == MODE_SAT);
   assign w_base = base_of(w_mode, 32'(i_rollover_val)) ? ONE : '0;

   // NOTE: every output of this always_comb gets a default first so no path
   // leaves one unassigned; that is what keeps it free of inferred latches.
   always_comb begin
      o_next_count     = i_count;
      o_terminal_event = 1'b0;
      o_terminal_val   = i_count_up ? i_rollover_val : w_base;
      if (i_count_up) begin
         // >= rather than == so a count loaded above rollover_val still wraps
         // instead of running on to the all-ones overflow.
         if (i_count >= i_rollover_val) begin
            o_terminal_event = 1'b1;
            o_next_count     = w_sat ? i_count : w_base;
         end else begin
            o_next_count = i_count + ONE;
         end
      end else begin
         if (i_count <= w_base) begin
            o_terminal_event = 1'b1;
            o_next_count     = w_sat ? i_count : i_rollover_val;
         end else begin
            o_next_count = i_count - ONE;
         end
      end
   end

endmodule

// File: rtl/flex_counter_ud.sv
// ---------------------------------------------------------------------------
// flex_counter_ud
// Parametrised up/down counter with synchronous clear/load and selectable
// terminal behaviour (wrap-to-1, wrap-to-0, saturate). All outputs registered.
// Ports:
//   clk, n_rst          clock (rising edge), async active-low reset
//   clear               synchronous clear, highest priority
//   load, load_val      synchronous parallel load
//   count_enable        advance one step
//   count_up            1 = up, 0 = down
//   mode                cnt_mode_t terminal behaviour
//   rollover_val        upper terminal value
//   count_out           current count
//   rollover_flag       count_out equals terminal for current direction
//   wrap_pulse          one-cycle strobe after each enabled terminal event
// ---------------------------------------------------------------------------
module flex_counter_ud
   import flex_cnt_pkg::*;
#(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    load,
   input  logic [NUM_CNT_BITS-1:0] load_val,
   input  logic                    count_enable,
   input  logic                    count_up,
   input  logic [1:0]              mode,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag,
   output logic                    wrap_pulse
);

   logic [NUM_CNT_BITS-1:0] r_count;
   logic                    r_flag;
   logic                    r_pulse;

   logic [NUM_CNT_BITS-1:0] w_step_count;
   logic                    w_term_event;
   logic [NUM_CNT_BITS-1:0] w_term_val;

   logic [NUM_CNT_BITS-1:0] w_count_d;
   logic                    w_flag_d;
   logic                    w_pulse_d;

   flex_cnt_step #(
      .NUM_CNT_BITS (NUM_CNT_BITS)
   ) u_step (
      .i_count          (r_count),
      .i_count_up       (count_up),
      .i_mode           (mode),
      .i_rollover_val   (rollover_val),
      .o_next_count     (w_step_count),
      .o_terminal_event (w_term_event),
      .o_terminal_val   (w_term_val)
   );

   // Priority clear > load > enable > hold. The flag is computed from the
   // value about to be registered so it lines up with count_out exactly.
   always_comb begin
      w_count_d = r_count;
      w_flag_d  = (r_count == w_term_val);
      w_pulse_d = 1'b0;
      if (clear) begin
         w_count_d = '0;
         w_flag_d  = 1'b0;
      end else if (load) begin
         w_count_d = load_val;
         w_flag_d  = (load_val == w_term_val);
      end else if (count_enable) begin
         w_count_d = w_step_count;
         w_flag_d  = (w_step_count == w_term_val);
         w_pulse_d = w_term_event;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_count <= '0;
         r_flag  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_count <= w_count_d;
         r_flag  <= w_flag_d;
         r_pulse <= w_pulse_d;
      end
   end

   assign count_out     = r_count;
   assign rollover_flag = r_flag;
   assign wrap_pulse    = r_pulse;

endmodule

// File: tb/tb_flex_counter_ud.sv
// ---------------------------------------------------------------------------
// tb_flex_counter_ud
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a behavioural integer model of the counter rules.
// ---------------------------------------------------------------------------
module tb_flex_counter_ud;
   import flex_cnt_pkg::*;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          clear;
   logic          load;
   logic [N-1:0]  load_val;
   logic          count_enable;
   logic          count_up;
   logic [1:0]    mode;
   logic [N-1:0]  rollover_val;
   logic [N-1:0]  count_out;
   logic          rollover_flag;
   logic          wrap_pulse;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state
   int m_count = 0;
   int m_flag  = 0;
   int m_pulse = 0;

   flex_counter_ud #(.NUM_CNT_BITS(N)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear),
      .load          (load),
      .load_val      (load_val),
      .count_enable  (count_enable),
      .count_up      (count_up),
      .mode          (mode),
      .rollover_val  (rollover_val),
      .count_out     (count_out),
      .rollover_flag (rollover_flag),
      .wrap_pulse    (wrap_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Counter rules stated directly: the lower terminal is 1 only in the
   // wrap-to-1 behaviours with a nonzero top; a step past a terminal either
   // jumps to the opposite terminal or stays put when saturating.
   task automatic model_step(input bit c, input bit l, input int lv, input bit e,
                             input bit up, input int md, input int rv);
      int lo, target, nxt;
      bit hit;
      lo     = ((md == 0 || md == 3) && rv != 0) ? 1 : 0;
      target = up ? rv : lo;
      hit    = 0;
      nxt    = m_count;
      if (c) begin
         m_count = 0; m_flag = 0; m_pulse = 0;
         return;
      end
      if (l) nxt = lv;
      else if (e) begin
         if (up && m_count >= rv) begin
            hit = 1; nxt = (md == 2) ? m_count : lo;
         end else if (up) nxt = m_count + 1;
         else if (m_count <= lo) begin
            hit = 1; nxt = (md == 2) ? m_count : rv;
         end else nxt = m_count - 1;
      end
      m_count = nxt;
      m_flag  = (nxt == target) ? 1 : 0;
      m_pulse = hit ? 1 : 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".count"}, int'(count_out), m_count);
      check({tag, ".flag"},  int'(rollover_flag), m_flag);
      check({tag, ".pulse"}, int'(wrap_pulse), m_pulse);
   endtask

   // One clock with the given inputs; outputs checked 1 time unit after edge.
   task automatic cyc(input string tag, input bit c, input bit l, input int lv,
                      input bit e, input bit up, input cnt_mode_t md, input int rv);
      clear        = c;
      load         = l;
      load_val     = N'(lv);
      count_enable = e;
      count_up     = up;
      mode         = md;
      rollover_val = N'(rv);
      @(posedge clk);
      model_step(c, l, lv, e, up, int'(md), rv);
      #1;
      check_all(tag);
   endtask

   initial begin
      int exp1 [7] = '{1, 2, 3, 4, 5, 1, 2};
      int exp2 [4] = '{1, 0, 3, 2};
      n_rst = 1'b0; clear = 0; load = 0; load_val = '0; count_enable = 0;
      count_up = 1; mode = MODE_WRAP1; rollover_val = N'(5);
      #2;
      check("reset.count", int'(count_out), 0);
      check("reset.flag",  int'(rollover_flag), 0);
      check("reset.pulse", int'(wrap_pulse), 0);
      @(posedge clk); #1; n_rst = 1'b1;

      // 1: WRAP1 up to 5, legacy wrap to 1
      for (int i = 0; i < 7; i++) begin
         cyc("t1", 0, 0, 0, 1, 1, MODE_WRAP1, 5);
         check("t1.seq", int'(count_out), exp1[i]);
         check("t1.flag_c", int'(rollover_flag), (exp1[i] == 5) ? 1 : 0);
         check("t1.pulse_c", int'(wrap_pulse), (i == 5) ? 1 : 0);
      end

      // 2: WRAP0 down, rollover 3
      cyc("t2.load", 0, 1, 2, 0, 0, MODE_WRAP0, 3);
      check("t2.load_c", int'(count_out), 2);
      for (int i = 0; i < 4; i++) begin
         cyc("t2", 0, 0, 0, 1, 0, MODE_WRAP0, 3);
         check("t2.seq", int'(count_out), exp2[i]);
         check("t2.pulse_c", int'(wrap_pulse), (exp2[i] == 3) ? 1 : 0);
      end
      cyc("t2.ld0", 0, 1, 1, 0, 0, MODE_WRAP0, 3);
      cyc("t2.to0", 0, 0, 0, 1, 0, MODE_WRAP0, 3);
      for (int i = 0; i < 3; i++) begin
         cyc("t2.hold", 0, 0, 0, 0, 0, MODE_WRAP0, 3);
         check("t2.hold_c", int'(count_out), 0);
         check("t2.hold_f", int'(rollover_flag), 1);
      end

      // 3: SAT up to 9, then step down
      cyc("t3.load", 0, 1, 7, 0, 1, MODE_SAT, 9);
      for (int i = 0; i < 5; i++) begin
         cyc("t3", 0, 0, 0, 1, 1, MODE_SAT, 9);
         check("t3.seq", int'(count_out), (i == 0) ? 8 : 9);
         check("t3.pulse_c", int'(wrap_pulse), (i >= 2) ? 1 : 0);
      end
      cyc("t3.down", 0, 0, 0, 1, 0, MODE_SAT, 9);
      check("t3.down_c", int'(count_out), 8);
      check("t3.down_f", int'(rollover_flag), 0);

      // 4: priority
      cyc("t4.all", 1, 1, 6, 1, 1, MODE_WRAP1, 9);
      check("t4.all_c", int'(count_out), 0);
      cyc("t4.ld_en", 0, 1, 6, 1, 1, MODE_WRAP1, 9);
      check("t4.ld_en_c", int'(count_out), 6);

      // 5: out of range load, and WRAP1 with rollover 0
      cyc("t5.load", 0, 1, 12, 0, 1, MODE_WRAP0, 5);
      cyc("t5.wrap", 0, 0, 0, 1, 1, MODE_WRAP0, 5);
      check("t5.wrap_c", int'(count_out), 0);
      check("t5.wrap_p", int'(wrap_pulse), 1);
      for (int i = 0; i < 3; i++) begin
         cyc("t5.rv0", 0, 0, 0, 1, 1, MODE_WRAP1, 0);
         check("t5.rv0_c", int'(count_out), 0);
         check("t5.rv0_f", int'(rollover_flag), 1);
         check("t5.rv0_p", int'(wrap_pulse), 1);
      end
      // all-ones top, WRAP0 up wraps to 0
      cyc("t5.ld15", 0, 1, 15, 0, 1, MODE_WRAP0, 15);
      cyc("t5.ones", 0, 0, 0, 1, 1, MODE_WRAP0, 15);
      check("t5.ones_c", int'(count_out), 0);

      // 6: async reset mid-cycle at count 4
      cyc("t6.ld", 0, 1, 3, 0, 1, MODE_WRAP1, 9);
      cyc("t6.up", 0, 0, 0, 1, 1, MODE_WRAP1, 9);
      check("t6.pre", int'(count_out), 4);
      #2;
      n_rst = 1'b0;
      #1;
      m_count = 0; m_flag = 0; m_pulse = 0;
      check("t6.async_c", int'(count_out), 0);
      check("t6.async_f", int'(rollover_flag), 0);
      check("t6.async_p", int'(wrap_pulse), 0);
      @(posedge clk); #1; n_rst = 1'b1;
      cyc("t6.resume", 0, 0, 0, 1, 1, MODE_WRAP1, 9);
      check("t6.resume_c", int'(count_out), 1);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         bit c, l, e, up;
         int rv, lv;
         cnt_mode_t md;
         c  = ($urandom % 20) == 0;
         l  = ($urandom % 8) == 0;
         e  = ($urandom % 4) != 0;
         up = ($urandom % 3) != 0;
         md = cnt_mode_t'($urandom % 4);
         case ($urandom % 4)
            0:       rv = 0;
            1:       rv = 15;
            default: rv = int'($urandom % 16);
         endcase
         lv = int'($urandom % 16);
         cyc("rnd", c, l, lv, e, up, md, rv);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
